// File: rtl/alu16_pg_stage.sv
// Two-stage 16-bit ALU front end: stage 1 registers operands and exports nibble P/G to an external
// 74182 CLA, then folds the returned carries into the result. Optional flags: ALU16_FLAGS_EN.
module alu16_pg_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [2:0]  in_op,
  input  logic        in_cin,
  output logic [3:0]  npb_o,
  output logic [3:0]  ngb_o,
  output logic        cn_o,
  input  logic        cla_cnx,
  input  logic        cla_cny,
  input  logic        cla_cnz,
  input  logic        cla_pbo,
  input  logic        cla_gbo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_f,
  output logic        out_cout,
  output logic        out_zero,
  output logic        out_neg,
  output logic        out_ovf
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_ADD0 = 3'b111;

  logic        s1_valid_q, s1_valid_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        cin_q, cin_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] f_q, f_d;
  logic        cout_q, cout_d;

  logic        accept, advance;
  logic        is_sub, is_arith;
  logic [15:0] bx, g, p, c, arith_f;
  logic [15:0] f_s1;
  logic        cout_s1;
  logic [3:0]  grp_g, grp_p, nib_cin;

  assign in_ready = ~s1_valid_q | ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign advance  = s1_valid_q & (~out_valid_q | out_ready);

  // Operand conditioning: SUB is a + ~b + 1, op 111 forces the carry-in low.
  assign is_sub   = (op_q == OP_SUB);
  assign is_arith = (op_q == OP_ADD) | (op_q == OP_SUB) | (op_q == OP_ADD0);
  assign bx       = is_sub ? ~b_q : b_q;
  assign cn_o     = is_sub ? 1'b1 : ((op_q == OP_ADD0) ? 1'b0 : cin_q);
  assign g        = a_q & bx;
  assign p        = a_q | bx;
  assign nib_cin  = {cla_cnz, cla_cny, cla_cnx, cn_o};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nibble
      logic [3:0] rc;
      assign grp_g[gi] = g[4*gi+3]
                       | (p[4*gi+3] & g[4*gi+2])
                       | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                       | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
      assign grp_p[gi] = &p[4*gi +: 4];
      // Carries ripple inside the nibble, seeded by the CLA-supplied nibble carry.
      assign rc[0] = nib_cin[gi];
      assign rc[1] = g[4*gi]   | (p[4*gi]   & rc[0]);
      assign rc[2] = g[4*gi+1] | (p[4*gi+1] & rc[1]);
      assign rc[3] = g[4*gi+2] | (p[4*gi+2] & rc[2]);
      assign c[4*gi +: 4] = rc;
    end
  endgenerate

  assign npb_o   = ~grp_p;
  assign ngb_o   = ~grp_g;
  assign arith_f = a_q ^ bx ^ c;
  assign cout_s1 = is_arith & (~cla_gbo | (~cla_pbo & cn_o));

  always_comb begin
    f_s1 = arith_f;
    case (op_q)
      OP_AND:  f_s1 = a_q & b_q;
      OP_OR:   f_s1 = a_q | b_q;
      OP_XOR:  f_s1 = a_q ^ b_q;
      OP_PASS: f_s1 = a_q;
      OP_NOT:  f_s1 = ~a_q;
      default: f_s1 = arith_f;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cin_d       = cin_q;
    f_d         = f_q;
    cout_d      = cout_q;
    s1_valid_d  = accept | (s1_valid_q & ~advance);
    out_valid_d = advance | (out_valid_q & ~out_ready);
    if (accept) begin
      a_d   = in_a;
      b_d   = in_b;
      op_d  = in_op;
      cin_d = in_cin;
    end
    if (advance) begin
      f_d    = f_s1;
      cout_d = cout_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      cout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_f     = f_q;
  assign out_cout  = cout_q;

`ifdef ALU16_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, ovf_s1;

  // Overflow: like-signed operands (after b inversion) producing a result of the other sign.
  assign ovf_s1 = is_arith & (a_q[15] == bx[15]) & (f_s1[15] != a_q[15]);

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    if (advance) begin
      zero_d = (f_s1 == 16'h0000);
      neg_d  = f_s1[15];
      ovf_d  = ovf_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_zero = zero_q;
  assign out_neg  = neg_q;
  assign out_ovf  = ovf_q;
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
  assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu16_pg_stage.sv
// Bench for alu16_pg_stage: models the external 74182 CLA, drives directed and random traffic,
// and scores results against an integer-arithmetic reference model. Honors ALU16_FLAGS_EN.
module tb_alu16_pg_stage;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        cin;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        in_cin;
  logic [3:0]  npb_o, ngb_o;
  logic        cn_o;
  logic        cla_cnx, cla_cny, cla_cnz, cla_pbo, cla_gbo;
  logic        out_valid, out_ready;
  logic [15:0] out_f;
  logic        out_cout, out_zero, out_neg, out_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_out    = 0;
  bit idle     = 1'b0;

  req_t        stim_q[$];
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  alu16_pg_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .npb_o(npb_o), .ngb_o(ngb_o), .cn_o(cn_o),
    .cla_cnx(cla_cnx), .cla_cny(cla_cny), .cla_cnz(cla_cnz),
    .cla_pbo(cla_pbo), .cla_gbo(cla_gbo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_cout(out_cout),
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf)
  );

  // External 74182 carry-lookahead unit (active-low group P/G in and out).
  always_comb begin
    logic [3:0] gg, pp;
    logic c1, c2, c3;
    gg = ~ngb_o;
    pp = ~npb_o;
    c1 = gg[0] | (pp[0] & cn_o);
    c2 = gg[1] | (pp[1] & c1);
    c3 = gg[2] | (pp[2] & c2);
    cla_cnx = c1;
    cla_cny = c2;
    cla_cnz = c3;
    cla_gbo = ~(gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]));
    cla_pbo = ~(&pp);
  end

  // Returns {f, cout, zero, neg, ovf}.
  function automatic logic [19:0] ref_model(req_t r);
    logic [15:0] f;
    logic co, ov;
    int sa, sb, sr, us;
    sa = int'($signed(r.a));
    sb = int'($signed(r.b));
    co = 1'b0;
    ov = 1'b0;
    sr = 0;
    us = 0;
    f  = '0;
    case (r.op)
      3'b000: begin us = int'(r.a) + int'(r.b) + int'(r.cin); sr = sa + sb + int'(r.cin); end
      3'b001: begin us = int'(r.a) - int'(r.b); sr = sa - sb; end
      3'b111: begin us = int'(r.a) + int'(r.b); sr = sa + sb; end
      default: ;
    endcase
    case (r.op)
      3'b000, 3'b111: begin f = us[15:0]; co = us[16]; ov = (sr > 32767) || (sr < -32768); end
      3'b001: begin f = us[15:0]; co = (r.a >= r.b); ov = (sr > 32767) || (sr < -32768); end
      3'b010: f = r.a & r.b;
      3'b011: f = r.a | r.b;
      3'b100: f = r.a ^ r.b;
      3'b101: f = r.a;
      default: f = ~r.a;
    endcase
`ifdef ALU16_FLAGS_EN
    return {f, co, (f == 16'h0000), f[15], ov};
`else
    return {f, co, 3'b000};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic req_t mk(logic [15:0] a, logic [15:0] b, logic [2:0] op, logic cin);
    req_t r;
    r.a = a; r.b = b; r.op = op; r.cin = cin;
    return r;
  endfunction

  task automatic drive();
    if (stim_q.size() > 0 && !idle) begin
      in_valid = 1'b1;
      in_a     = stim_q[0].a;
      in_b     = stim_q[0].b;
      in_op    = stim_q[0].op;
      in_cin   = stim_q[0].cin;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, observe handshakes, advance to the next falling edge.
  task automatic step();
    logic [19:0] e;
    drive();
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("no_stale", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        n_out++;
        $display("txn %0d f=%h cout=%b z=%b n=%b v=%b", n_out, out_f, out_cout, out_zero, out_neg, out_ovf);
        check("result", {12'd0, out_f, out_cout, out_zero, out_neg, out_ovf}, {12'd0, e});
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_model(stim_q[0]));
      void'(stim_q.pop_front());
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check("drain", stim_q.size() + exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    logic [19:0] held;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_npb", {28'd0, npb_o}, 32'hF);
    check("rst_ngb", {28'd0, ngb_o}, 32'hF);
    check("rst_cn", {31'd0, cn_o}, 32'd0);
    check("rst_out", {12'd0, out_f, out_cout, out_zero, out_neg, out_ovf}, 32'd0);
    rst = 1'b0;

    // ADD 0x00FF + 0x0001: stage-1 group signals and one-cycle latency
    stim_q.push_back(mk(16'h00FF, 16'h0001, 3'b000, 1'b0));
    step();
    check("s1_npb", {28'd0, npb_o}, 32'hC);
    check("s1_ngb", {28'd0, ngb_o}, 32'hE);
    check("s1_cn", {31'd0, cn_o}, 32'd0);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("f_0100", {16'd0, out_f}, 32'h0100);
    drain(20);

    // Arithmetic corner cases
    stim_q.push_back(mk(16'hFFFF, 16'h0001, 3'b000, 1'b0));
    stim_q.push_back(mk(16'h0000, 16'h0001, 3'b001, 1'b0));
    stim_q.push_back(mk(16'h0005, 16'h0003, 3'b001, 1'b0));
    stim_q.push_back(mk(16'h7FFF, 16'h0001, 3'b000, 1'b0));
    stim_q.push_back(mk(16'h1234, 16'h0FFF, 3'b111, 1'b1));
    stim_q.push_back(mk(16'hA5A5, 16'h0F0F, 3'b110, 1'b1));
    drain(40);

    // Backpressure: three offered with out_ready low
    out_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) stim_q.push_back(mk(16'h1000 * 16'(i + 1), 16'h0011, 3'b000, 1'b0));
    step(); step(); step();
    drive();
    #1;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_accepted", n_acc - acc0, 32'd2);
    held = {out_f, out_cout, out_zero, out_neg, out_ovf};
    step(); step();
    check("bp_hold", {12'd0, out_f, out_cout, out_zero, out_neg, out_ovf}, {12'd0, held});
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drain(20);
    check("bp_all_accepted", n_acc - acc0, 32'd3);

    // Reset with both stages full
    out_ready = 1'b0;
    stim_q.push_back(mk(16'h4444, 16'h1111, 3'b001, 1'b0));
    stim_q.push_back(mk(16'h5555, 16'h2222, 3'b011, 1'b0));
    step(); step(); step();
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    stim_q.delete();
    exp_q.delete();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("no_stale_after_rst", {31'd0, out_valid}, 32'd0);

    // Random traffic with random backpressure and input gaps
    for (int i = 0; i < 300; i++)
      stim_q.push_back(mk(pick_operand(), pick_operand(), 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0))));
    for (int k = 0; k < 3000 && (stim_q.size() > 0 || exp_q.size() > 0); k++) begin
      out_ready = ($urandom_range(3, 0) != 0);
      idle      = ($urandom_range(4, 0) == 0);
      step();
    end
    idle = 1'b0;
    out_ready = 1'b1;
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu16_pg_stage.md
ALU16_PG_STAGE -- requirements
Module: alu16_pg_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports in order: clk, rst.
REQ-002 clk  in  1  rising-edge clock for all registers.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  operand request; in_ready  out  1  stage 1 can accept.
REQ-005 in_a, in_b  in  16  operands; in_op  in  3  operation code; in_cin  in  1  active-high carry-in.
REQ-006 npb_o, ngb_o  out  4  active-low per-nibble group propagate and generate, driven to the external cla_74182 nPB/nGB.
REQ-007 cn_o  out  1  effective active-high carry-in, driven to the CLA Cn.
REQ-008 cla_cnx, cla_cny, cla_cnz  in  1  active-high carries into nibbles 1, 2 and 3, returned by the CLA.
REQ-009 cla_pbo, cla_gbo  in  1  CLA group outputs (active-low P, active-low G).
REQ-010 out_valid  out  1; out_ready  in  1; out_f  out  16  result; out_cout  out  1  carry-out.
REQ-011 out_zero, out_neg, out_ovf  out  1  status flags (see REQ-027).

Function
REQ-012 op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS A, 110 NOT A, 111 ADD with cin forced to 0.
REQ-013 Stage 1 SHALL register a, b, op, cin on in_valid & in_ready.
REQ-014 From the stage-1 registers, combinationally: bx = ~b for SUB, else b; cn_o = 1 for SUB, 0 for op 111, else cin.
REQ-015 Per bit: g = a & bx, p = a | bx; per nibble: G = g3|p3g2|p3p2g1|p3p2p1g0, P = p3&p2&p1&p0.
REQ-016 npb_o[k] = ~P_k and ngb_o[k] = ~G_k for all ops; logic ops ignore the returned carries.
REQ-017 Nibble carry-ins SHALL be cn_o, cla_cnx, cla_cny and cla_cnz for nibbles 0-3; arithmetic result = a ^ bx ^ ripple-within-nibble carries.
REQ-018 cout = ~cla_gbo | (~cla_pbo & cn_o) for arithmetic ops; 0 for logic ops.
REQ-019 Stage 2 (output register) SHALL capture f, cout and flags when stage 1 is valid and (~out_valid | out_ready).
REQ-020 Latency: a transaction accepted at edge k SHALL present out_valid after edge k+1 when not stalled; throughput is 1 per cycle.
REQ-021 in_ready = ~s1_valid | ~out_valid | out_ready; a combinational path from out_ready to in_ready is permitted.
REQ-022 out_f, out_cout and flags SHALL hold stable while out_valid & ~out_ready.
REQ-023 Simultaneous accept and advance SHALL load the new operands into stage 1 in the same edge; order SHALL be strictly FIFO with no drop or duplication.
REQ-024 SUB carry semantics: out_cout = 1 means no borrow.

Reset
REQ-025 On rst at an edge: s1_valid = 0, out_valid = 0, out_f = 0, out_cout = 0, all flags = 0, stage-1 operands = 0 (npb_o = 4'hF, ngb_o = 4'hF, cn_o = 0).
REQ-026 Reset mid-operation SHALL discard in-flight transactions; in_ready = 1 from the first cycle after reset.

Configuration
REQ-027 Macro ALU16_FLAGS_EN defined: out_zero = (f == 0); out_neg = f[15]; out_ovf = signed overflow for ADD/SUB/111 (operand sign bits of a and bx equal, f[15] differing), 0 for logic ops.
REQ-028 Macro ALU16_FLAGS_EN undefined: the flag ports SHALL remain present, tied to 0, with no flag logic or registers.

Verification
REQ-029 ADD 0x00FF + 0x0001, cin 0 -> npb_o/ngb_o in stage 1 with ngb_o[0] = 0; out_f = 0x0100, cout 0, zero 0.
REQ-030 ADD 0xFFFF + 0x0001, cin 0 -> out_f = 0x0000, cout 1, zero 1 (flags build).
REQ-031 SUB 0x0000 - 0x0001 -> out_f = 0xFFFF, cout 0, neg 1; SUB 0x0005 - 0x0003 -> 0x0002, cout 1.
REQ-032 ADD 0x7FFF + 0x0001 -> 0x8000, ovf 1, neg 1; without ALU16_FLAGS_EN -> all flags 0.
REQ-033 Backpressure: out_ready = 0 while 3 requests are offered -> 2 accepted, in_ready = 0; release out_ready -> results emerge in order, third accepted.
REQ-034 rst asserted with both stages valid -> out_valid = 0 and in_ready = 1 the next cycle; no stale result appears.
